// File: rtl/ex_mem_pipe_if.sv
// EX->MEM pipeline bus: stage control, EX-side payload, registered MEM-side
// payload and the multi-cycle feedback returned to EX.
interface ex_mem_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int CNT_W     = 2,
  parameter int BUBBLE_W  = 16
);

  // stage control
  logic                   flush;
  logic                   stall_ex;
  logic                   stall_mem;

  // EX-side payload
  logic                   ex_valid;
  logic [REGADDR_W-1:0]   ex_wd;
  logic                   ex_wreg;
  logic [DATA_W-1:0]      ex_wdata;
  logic                   ex_whilo;
  logic [DATA_W-1:0]      ex_hi;
  logic [DATA_W-1:0]      ex_lo;
  logic [ALUOP_W-1:0]     ex_aluop;
  logic [DATA_W-1:0]      ex_mem_addr;
  logic [DATA_W-1:0]      ex_reg2;
  logic [2*DATA_W-1:0]    ex_hilo_temp;
  logic [CNT_W-1:0]       ex_cnt;

  // MEM-side registered payload
  logic                   mem_valid;
  logic [REGADDR_W-1:0]   mem_wd;
  logic                   mem_wreg;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_whilo;
  logic [DATA_W-1:0]      mem_hi;
  logic [DATA_W-1:0]      mem_lo;
  logic [ALUOP_W-1:0]     mem_aluop;
  logic [DATA_W-1:0]      mem_mem_addr;
  logic [DATA_W-1:0]      mem_reg2;

  // feedback to EX and statistics
  logic [2*DATA_W-1:0]    hilo_temp_o;
  logic [CNT_W-1:0]       cnt_o;
  logic [BUBBLE_W-1:0]    bubble_cnt;

  // the side that owns the EX stage and consumes the registered outputs
  modport master (
    output flush, stall_ex, stall_mem,
    output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
    output ex_aluop, ex_mem_addr, ex_reg2, ex_hilo_temp, ex_cnt,
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  mem_aluop, mem_mem_addr, mem_reg2,
    input  hilo_temp_o, cnt_o, bubble_cnt
  );

  // the pipeline register itself
  modport slave (
    input  flush, stall_ex, stall_mem,
    input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
    input  ex_aluop, ex_mem_addr, ex_reg2, ex_hilo_temp, ex_cnt,
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output mem_aluop, mem_mem_addr, mem_reg2,
    output hilo_temp_o, cnt_o, bubble_cnt
  );

endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with flush, hold and bubble insertion.
// While EX is stalled the MADD/MSUB partial product and cycle index are
// captured and handed back to EX; inserted bubbles are counted (saturating).
module ex_mem_pipe #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int CNT_W     = 2,
  parameter int BUBBLE_W  = 16
) (
  input logic          clk,
  input logic          rst,
  ex_mem_pipe_if.slave bus
);

  // what this edge does to the stage, highest priority first after reset
  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_ADVANCE = 2'd3
  } action_e;

  // everything that travels EX->MEM as one unit
  typedef struct packed {
    logic                 valid;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [DATA_W-1:0]    wdata;
    logic                 whilo;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
    logic [ALUOP_W-1:0]   aluop;
    logic [DATA_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    reg2;
  } payload_t;

  action_e             action;
  payload_t            ex_payload;
  payload_t            payload_q;
  logic [2*DATA_W-1:0] hilo_temp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BUBBLE_W-1:0] bubble_q;
  logic [BUBBLE_W-1:0] bubble_inc;

  // gather the EX-side fields into one payload word
  always_comb begin
    ex_payload          = '0;
    ex_payload.valid    = bus.ex_valid;
    ex_payload.wd       = bus.ex_wd;
    ex_payload.wreg     = bus.ex_wreg;
    ex_payload.wdata    = bus.ex_wdata;
    ex_payload.whilo    = bus.ex_whilo;
    ex_payload.hi       = bus.ex_hi;
    ex_payload.lo       = bus.ex_lo;
    ex_payload.aluop    = bus.ex_aluop;
    ex_payload.mem_addr = bus.ex_mem_addr;
    ex_payload.reg2     = bus.ex_reg2;
  end

  // pick the stage action; stall_mem alone is treated as a hold as well
  always_comb begin
    action = ACT_ADVANCE;
    if (bus.flush) begin
      action = ACT_FLUSH;
    end else if (bus.stall_mem) begin
      action = ACT_HOLD;
    end else if (bus.stall_ex) begin
      action = ACT_BUBBLE;
    end
  end

  // bubble counter stops at all-ones instead of wrapping
  always_comb begin
    bubble_inc = bubble_q;
    if (bubble_q != {BUBBLE_W{1'b1}}) begin
      bubble_inc = bubble_q + {{(BUBBLE_W-1){1'b0}}, 1'b1};
    end
  end

  // MEM payload: copy on advance, keep on hold, zero (NOP) otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q <= '0;
    end else begin
      case (action)
        ACT_ADVANCE: payload_q <= ex_payload;
        ACT_HOLD:    payload_q <= payload_q;
        default:     payload_q <= '0;
      endcase
    end
  end

  // multi-cycle feedback: captured only while EX sits in a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      hilo_temp_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (action)
        ACT_BUBBLE: begin
          hilo_temp_q <= bus.ex_hilo_temp;
          cnt_q       <= bus.ex_cnt;
        end
        ACT_HOLD: begin
          hilo_temp_q <= hilo_temp_q;
          cnt_q       <= cnt_q;
        end
        default: begin
          hilo_temp_q <= '0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  // bubble statistics survive flushes; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (action == ACT_BUBBLE) begin
      bubble_q <= bubble_inc;
    end
  end

  assign bus.mem_valid    = payload_q.valid;
  assign bus.mem_wd       = payload_q.wd;
  assign bus.mem_wreg     = payload_q.wreg;
  assign bus.mem_wdata    = payload_q.wdata;
  assign bus.mem_whilo    = payload_q.whilo;
  assign bus.mem_hi       = payload_q.hi;
  assign bus.mem_lo       = payload_q.lo;
  assign bus.mem_aluop    = payload_q.aluop;
  assign bus.mem_mem_addr = payload_q.mem_addr;
  assign bus.mem_reg2     = payload_q.reg2;
  assign bus.hilo_temp_o  = hilo_temp_q;
  assign bus.cnt_o        = cnt_q;
  assign bus.bubble_cnt   = bubble_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a vector table walks one default-width
// instance through reset, advance, bubbles, holds and flushes; a second
// instance with a 2-bit bubble counter covers saturation.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
  } payload_t;

  typedef struct {
    logic [3:0]  ctrl;
    payload_t    pin;
    logic [63:0] ht;
    logic [1:0]  cnt;
    payload_t    pexp;
    logic [63:0] eht;
    logic [1:0]  ecnt;
    logic [15:0] ebub;
  } vec_t;

  logic clk;
  logic rst;
  logic rst2;
  int   tests;
  int   failures;
  vec_t vecs[$];

  ex_mem_pipe_if #(.DATA_W(32), .REGADDR_W(5), .ALUOP_W(8), .CNT_W(2), .BUBBLE_W(16)) bus ();
  ex_mem_pipe_if #(.DATA_W(32), .REGADDR_W(5), .ALUOP_W(8), .CNT_W(2), .BUBBLE_W(2))  bus2 ();

  ex_mem_pipe #(.DATA_W(32), .REGADDR_W(5), .ALUOP_W(8), .CNT_W(2), .BUBBLE_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ex_mem_pipe #(.DATA_W(32), .REGADDR_W(5), .ALUOP_W(8), .CNT_W(2), .BUBBLE_W(2)) dut_sat (
    .clk(clk),
    .rst(rst2),
    .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic [3:0] ctrl, input payload_t pin,
                                 input logic [63:0] ht, input logic [1:0] cnt,
                                 input payload_t pexp, input logic [63:0] eht,
                                 input logic [1:0] ecnt, input logic [15:0] ebub);
    vec_t v;
    v.ctrl = ctrl;  v.pin = pin;   v.ht = ht;     v.cnt = cnt;
    v.pexp = pexp;  v.eht = eht;   v.ecnt = ecnt; v.ebub = ebub;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    {rst, bus.flush, bus.stall_ex, bus.stall_mem} = v.ctrl;
    bus.ex_valid     = v.pin.valid;
    bus.ex_wd        = v.pin.wd;
    bus.ex_wreg      = v.pin.wreg;
    bus.ex_wdata     = v.pin.wdata;
    bus.ex_whilo     = v.pin.whilo;
    bus.ex_hi        = v.pin.hi;
    bus.ex_lo        = v.pin.lo;
    bus.ex_aluop     = v.pin.aluop;
    bus.ex_mem_addr  = v.pin.addr;
    bus.ex_reg2      = v.pin.reg2;
    bus.ex_hilo_temp = v.ht;
    bus.ex_cnt       = v.cnt;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive2(input logic r, input logic sx, input logic sm);
    rst2           = r;
    bus2.stall_ex  = sx;
    bus2.stall_mem = sm;
    @(posedge clk);
    #1;
  endtask

  payload_t pz, pr1, pr2, pa, pm, pb, pc, ph1, ph2, ph3, got_p;

  initial begin
    tests    = 0;
    failures = 0;

    rst2              = 1'b1;
    bus2.flush        = 1'b0;
    bus2.stall_ex     = 1'b0;
    bus2.stall_mem    = 1'b0;
    bus2.ex_valid     = 1'b1;
    bus2.ex_wd        = 5'd5;
    bus2.ex_wreg      = 1'b1;
    bus2.ex_wdata     = 32'hDEADBEEF;
    bus2.ex_whilo     = 1'b1;
    bus2.ex_hi        = 32'h1;
    bus2.ex_lo        = 32'h2;
    bus2.ex_aluop     = 8'h23;
    bus2.ex_mem_addr  = 32'h1000;
    bus2.ex_reg2      = 32'h55;
    bus2.ex_hilo_temp = 64'h1_0000_0002;
    bus2.ex_cnt       = 2'd1;

    pz  = '0;
    pr1 = '{1'b1, 5'd7,  1'b1, 32'h12345678, 1'b1, 32'h1,  32'h2,  8'hFF, 32'h44,   32'h55};
    pr2 = '{1'b1, 5'd31, 1'b0, 32'hFFFFFFFF, 1'b1, 32'hA5, 32'h5A, 8'h01, 32'h88,   32'h99};
    pa  = '{1'b1, 5'd5,  1'b1, 32'hDEADBEEF, 1'b0, 32'h0,  32'h0,  8'h23, 32'h1000, 32'h55};
    pm  = '{1'b1, 5'd0,  1'b0, 32'h0,        1'b1, 32'h1,  32'h2,  8'h10, 32'h0,    32'h0};
    pb  = '{1'b1, 5'd3,  1'b1, 32'hCAFEF00D, 1'b0, 32'h0,  32'h0,  8'hA3, 32'h2000, 32'h7788};
    pc  = '{1'b0, 5'd4,  1'b0, 32'h99,       1'b0, 32'h3,  32'h4,  8'h20, 32'h3000, 32'h11};
    ph1 = '{1'b1, 5'd9,  1'b1, 32'h11111111, 1'b1, 32'h22, 32'h33, 8'h44, 32'h55,   32'h66};
    ph2 = '{1'b1, 5'd10, 1'b1, 32'h22222222, 1'b0, 32'h77, 32'h88, 8'h99, 32'hAA,   32'hBB};
    ph3 = '{1'b0, 5'd11, 1'b0, 32'h33333333, 1'b1, 32'hCC, 32'hDD, 8'hEE, 32'hFF,   32'h12};

    // ctrl = {rst, flush, stall_ex, stall_mem}
    addVec(4'b1010, pr1, 64'hABCD,        2'd3, pz, 64'h0,           2'd0, 16'd0);
    addVec(4'b1000, pr2, 64'h1234,        2'd2, pz, 64'h0,           2'd0, 16'd0);
    addVec(4'b0000, pa,  64'hFFFF,        2'd3, pa, 64'h0,           2'd0, 16'd0);
    addVec(4'b0010, pm,  64'h1_0000_0002, 2'd1, pz, 64'h1_0000_0002, 2'd1, 16'd1);
    addVec(4'b0010, pm,  64'h1_0000_0002, 2'd1, pz, 64'h1_0000_0002, 2'd1, 16'd2);
    addVec(4'b0000, pm,  64'h1_0000_0002, 2'd1, pm, 64'h0,           2'd0, 16'd2);
    addVec(4'b0000, pb,  64'h0,           2'd0, pb, 64'h0,           2'd0, 16'd2);
    addVec(4'b0011, ph1, 64'h99,          2'd2, pb, 64'h0,           2'd0, 16'd2);
    addVec(4'b0011, ph2, 64'h88,          2'd3, pb, 64'h0,           2'd0, 16'd2);
    addVec(4'b0011, ph3, 64'h77,          2'd1, pb, 64'h0,           2'd0, 16'd2);
    addVec(4'b0010, ph1, 64'h55,          2'd2, pz, 64'h55,          2'd2, 16'd3);
    addVec(4'b0001, ph2, 64'h66,          2'd3, pz, 64'h55,          2'd2, 16'd3);
    addVec(4'b0010, pm,  64'h77,          2'd1, pz, 64'h77,          2'd1, 16'd4);
    addVec(4'b0110, pm,  64'h88,          2'd2, pz, 64'h0,           2'd0, 16'd4);
    addVec(4'b0000, pc,  64'h44,          2'd1, pc, 64'h0,           2'd0, 16'd4);
    addVec(4'b0101, ph3, 64'h33,          2'd3, pz, 64'h0,           2'd0, 16'd4);
    addVec(4'b1011, ph1, 64'h22,          2'd2, pz, 64'h0,           2'd0, 16'd0);
    addVec(4'b0000, pa,  64'h11,          2'd1, pa, 64'h0,           2'd0, 16'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      got_p = '{bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo,
                bus.mem_hi, bus.mem_lo, bus.mem_aluop, bus.mem_mem_addr, bus.mem_reg2};
      checkOutput($sformatf("v%0d payload", i),    256'(got_p),           256'(vecs[i].pexp));
      checkOutput($sformatf("v%0d hilo_temp", i),  256'(bus.hilo_temp_o), 256'(vecs[i].eht));
      checkOutput($sformatf("v%0d cnt_o", i),      256'(bus.cnt_o),       256'(vecs[i].ecnt));
      checkOutput($sformatf("v%0d bubble_cnt", i), 256'(bus.bubble_cnt),  256'(vecs[i].ebub));
    end

    // saturating 2-bit bubble counter
    drive2(1'b1, 1'b0, 1'b0);
    checkOutput("sat reset", 256'(bus2.bubble_cnt), 256'(0));
    drive2(1'b0, 1'b1, 1'b0);
    checkOutput("sat b1", 256'(bus2.bubble_cnt), 256'(1));
    drive2(1'b0, 1'b1, 1'b0);
    checkOutput("sat b2", 256'(bus2.bubble_cnt), 256'(2));
    drive2(1'b0, 1'b1, 1'b0);
    checkOutput("sat b3", 256'(bus2.bubble_cnt), 256'(3));
    drive2(1'b0, 1'b1, 1'b0);
    checkOutput("sat b4", 256'(bus2.bubble_cnt), 256'(3));
    drive2(1'b0, 1'b1, 1'b0);
    checkOutput("sat b5", 256'(bus2.bubble_cnt), 256'(3));
    checkOutput("sat valid", 256'(bus2.mem_valid), 256'(0));
    checkOutput("sat cnt_o", 256'(bus2.cnt_o), 256'(1));
    drive2(1'b0, 1'b1, 1'b1);
    checkOutput("sat hold", 256'(bus2.bubble_cnt), 256'(3));
    drive2(1'b0, 1'b0, 1'b0);
    checkOutput("sat advance", 256'(bus2.bubble_cnt), 256'(3));
    checkOutput("sat adv wdata", 256'(bus2.mem_wdata), 256'(32'hDEADBEEF));
    drive2(1'b1, 1'b1, 1'b0);
    checkOutput("sat rst", 256'(bus2.bubble_cnt), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
